// File: rtl/subtractor_serial_reg.sv
// Digit-serial registered subtractor: d = a - b - bi over WIDTH bits, DIGIT bits per cycle,
// with valid/ready handshakes. Defining SUB_OVERFLOW_EN adds the registered signed-overflow port ovf.
module subtractor_serial_reg #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_d;
  logic               r_bo;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_last;
  logic [DIGIT-1:0]   w_a_dig;
  logic [DIGIT-1:0]   w_b_dig;
  logic [DIGIT:0]     w_sub;
  logic [WIDTH-1:0]   w_res_next;

  assign d  = r_d;
  assign bo = r_bo;
  assign w_last = (r_cnt == CNT_W'(N - 1));

  // Current digit slice; the top bit of the (DIGIT+1)-bit difference is the borrow out.
  always_comb begin
    w_a_dig    = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    w_b_dig    = r_b[int'(r_cnt) * DIGIT +: DIGIT];
    w_sub      = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT{1'b0}}, r_borrow};
    w_res_next = r_res;
    w_res_next[int'(r_cnt) * DIGIT +: DIGIT] = w_sub[DIGIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_bo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bi;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          r_res    <= w_res_next;
          r_borrow <= w_sub[DIGIT];
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_d  <= w_res_next;
            r_bo <= w_sub[DIGIT];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // Signed overflow: operand signs differ and the result sign departs from the minuend's.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_BUSY && w_last) begin
      r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_subtractor_serial_reg.sv
// Scoreboard bench for subtractor_serial_reg: stimulus pushes model results, a negedge monitor pops on each handshake.
module tb_subtractor_serial_reg;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  subtractor_serial_reg #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef SUB_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbi);
    exp_t             e;
    longint unsigned  la, lb;
    la    = longint'(ma);
    lb    = longint'(mb) + longint'(mbi);
    e.d   = WIDTH'(la - lb);
    e.bo  = (la < lb);
    e.ovf = (ma[WIDTH-1] != mb[WIDTH-1]) && (e.d[WIDTH-1] != ma[WIDTH-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual d=%h bo=%b required no result", d, bo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result d=%h bo=%b ovf=%b expected d=%h bo=%b ovf=%b", d, bo, ovf, e.d, e.bo, e.ovf);
        check("result_d", d, e.d);
        check("result_bo", WIDTH'(bo), WIDTH'(e.bo));
`ifdef SUB_OVERFLOW_EN
        check("result_ovf", WIDTH'(ovf), WIDTH'(e.ovf));
`endif
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Issue one operation; checks latency and returns right after out_valid rises.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbi, input bit push);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (in_ready !== 1'b1 && wait_cnt < 60) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=%b required=1", in_ready);
      return;
    end
    a = ta; b = tb; bi = tbi; in_valid = 1'b1;
    if (push) exp_q.push_back(model(ta, tb, tbi));
    $display("issue a=%h b=%h bi=%b", ta, tb, tbi);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bi = $urandom_range(0, 1);
    check("busy_in_ready", WIDTH'(in_ready), '0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, N);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", WIDTH'(in_ready), 1);
    check("rst_out_valid", WIDTH'(out_valid), 0);
    check("rst_d", d, 0);
    check("rst_bo", WIDTH'(bo), 0);
    check("rst_ovf", WIDTH'(ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op; in_ready returns one edge after out_valid with out_ready high.
    do_op(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1);
    check("d_basic_direct", d, 32'h0000_000F);
    @(posedge clk); #1;
    check("ready_after_done", WIDTH'(in_ready), 1);
    check("valid_after_done", WIDTH'(out_valid), 0);
    check("d_kept_idle", d, 32'h0000_000F);

    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    check("ripple_d", d, 32'hFFFF_FFFF);
    check("ripple_bo", WIDTH'(bo), 1);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Backpressure: 5 stalled cycles with an in_valid pulse that must be ignored.
    out_ready = 1'b0;
    e = model(32'hA5A5_0000, 32'h0000_0001, 1'b1);
    do_op(32'hA5A5_0000, 32'h0000_0001, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("stall_valid", WIDTH'(out_valid), 1);
      check("stall_ready", WIDTH'(in_ready), 0);
      check("stall_d", d, e.d);
      check("stall_bo", WIDTH'(bo), WIDTH'(e.bo));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("no_ghost_accept", WIDTH'(out_valid), 0);

    // Reset on the second BUSY cycle discards the operation.
    a = 32'h0000_0100; b = 32'h0000_0001; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ready", WIDTH'(in_ready), 1);
    check("midrst_valid", WIDTH'(out_valid), 0);
    check("midrst_d", d, 0);
    check("midrst_bo", WIDTH'(bo), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", WIDTH'(out_valid), 0);
    end

    // Randomized phase with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = '0;
        2: rb = '1;
        default: begin end
      endcase
      do_op(ra, rb, 1'b1 & $urandom_range(0, 1), 1'b1);
    end
    rand_ready = 1'b0;
    #2 out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
